calculator_accumulator: RTL and testbench

CALCULATOR_ACCUMULATOR -- requirements
Module: calculator_accumulator

---
 rtl/calc_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/calculator_accumulator.sv | 133 +++++++++++++
 tb/tb_calculator_accumulator.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator accumulator.
package calc_pkg;

  localparam int ACC_W           = 14;
  localparam int BCD_W           = 16;
  localparam int BCD_DIGITS      = BCD_W / 4;

  localparam int SLIDER_WEIGHT_1 = 1;
  localparam int SLIDER_WEIGHT_2 = 10;
  localparam int SLIDER_WEIGHT_3 = 100;
  localparam int SLIDER_WEIGHT_4 = 1000;

  localparam int ACC_MAX_DEFAULT = 9999;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } calc_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/adjust iteration per clock,
// ACC_W iterations per conversion. A start while busy restarts from the new
// input value. done pulses for one cycle together with the new bcd value.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ACC_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int SH_W = BCD_W + ACC_W;

  logic [SH_W-1:0] shift_q;
  logic [SH_W-1:0] shift_next;
  logic [3:0]      iter_cnt;

  // Add 3 to every BCD digit that is 5 or more, then shift the whole word left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] a;
    a = s;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (a[ACC_W + 4*i +: 4] >= 4'd5) begin
        a[ACC_W + 4*i +: 4] = a[ACC_W + 4*i +: 4] + 4'd3;
      end
    end
    return {a[SH_W-2:0], 1'b0};
  endfunction

  assign shift_next = dd_step(shift_q);

  // Load on start, iterate while busy, publish the digits on the last iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      iter_cnt <= '0;
      bcd      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shift_q  <= {{BCD_W{1'b0}}, bin};
        iter_cnt <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        shift_q  <= shift_next;
        iter_cnt <= iter_cnt + 4'd1;
        if (iter_cnt == 4'(ACC_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= shift_next[SH_W-1 -: BCD_W];
        end
      end
    end
  end

endmodule

// File: rtl/calculator_accumulator.sv
// Calculator accumulator: adds the slider value on each enter press, clears on
// clear press, and keeps a BCD copy of the accumulator via bin2bcd_seq.
// Build option: define CALC_SATURATE_EN to clamp at ACC_MAX on overflow;
// without it the accumulator wraps past ACC_MAX.
module calculator_accumulator
  import calc_pkg::*;
#(
  parameter int ACC_MAX = ACC_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_clr,
  input  logic             button_ent,
  input  logic             slider_1,
  input  logic             slider_2,
  input  logic             slider_3,
  input  logic             slider_4,
  output logic [ACC_W-1:0] acc,
  output logic [BCD_W-1:0] bcd,
  output logic             bcd_valid,
  output logic             busy,
  output logic             overflow
);

  localparam int               SUM_W   = ACC_W + 1;
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(ACC_MAX);
  localparam logic [SUM_W-1:0] SW_1    = SUM_W'(SLIDER_WEIGHT_1);
  localparam logic [SUM_W-1:0] SW_2    = SUM_W'(SLIDER_WEIGHT_2);
  localparam logic [SUM_W-1:0] SW_3    = SUM_W'(SLIDER_WEIGHT_3);
  localparam logic [SUM_W-1:0] SW_4    = SUM_W'(SLIDER_WEIGHT_4);

  if (ACC_MAX < 1 || ACC_MAX > 9999) begin : g_acc_max_range
    $error("calculator_accumulator: ACC_MAX must lie in 1..9999");
  end

  // Accumulator value after an add whose sum exceeded ACC_MAX.
  function automatic logic [ACC_W-1:0] overflow_value(input logic [SUM_W-1:0] sum_in);
`ifdef CALC_SATURATE_EN
    return (sum_in > MAX_SUM) ? MAX_SUM[ACC_W-1:0] : sum_in[ACC_W-1:0];
`else
    return ACC_W'(sum_in - (MAX_SUM + SUM_W'(1)));
`endif
  endfunction

  calc_state_t      state;
  logic             ent_p0;
  logic             clr_p0;
  logic             ent_evt;
  logic             clr_evt;
  logic             add_ok;
  logic             conv_start;
  logic [SUM_W-1:0] sval;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_hit;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  assign ent_evt    = button_ent & ~ent_p0;
  assign clr_evt    = button_clr & ~clr_p0;
  assign sval       = (slider_4 ? SW_4 : '0) + (slider_3 ? SW_3 : '0)
                    + (slider_2 ? SW_2 : '0) + (slider_1 ? SW_1 : '0);
  assign sum        = {1'b0, acc} + sval;
  // Clear wins over a simultaneous enter; enter during a conversion is ignored.
  assign add_ok     = ent_evt & ~clr_evt & (state == IDLE);
  assign conv_start = clr_evt | add_ok;

  // Next accumulator value and overflow detection for this cycle's events.
  always_comb begin
    acc_next = acc;
    ovf_hit  = 1'b0;
    if (clr_evt) begin
      acc_next = '0;
    end else if (add_ok) begin
      if (sum <= MAX_SUM) begin
        acc_next = sum[ACC_W-1:0];
      end else begin
        acc_next = overflow_value(sum);
        ovf_hit  = 1'b1;
      end
    end
  end

  // The converter is started with the value acc takes on the same edge.
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (acc_next),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Edge detection, accumulator update and IDLE/CONV sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ent_p0    <= 1'b0;
      clr_p0    <= 1'b0;
      acc       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ent_p0 <= button_ent;
      clr_p0 <= button_clr;
      acc    <= acc_next;
      if (clr_evt) begin
        overflow <= 1'b0;
      end else if (ovf_hit) begin
        overflow <= 1'b1;
      end
      if (conv_start) begin
        state     <= CONV;
        busy      <= 1'b1;
        bcd_valid <= 1'b0;
      end else if (state == CONV && conv_done) begin
        state     <= IDLE;
        busy      <= 1'b0;
        bcd       <= conv_bcd;
        bcd_valid <= 1'b1;
      end else if (state == CONV && !conv_busy && !conv_done) begin
        // Converter idle without a pending result: never leave the FSM stuck.
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calculator_accumulator.sv
// Self-checking bench for calculator_accumulator with a behavioural model.
module tb_calculator_accumulator;

  localparam int MAX = 9999;
`ifdef CALC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        button_clr = 1'b0;
  logic        button_ent = 1'b0;
  logic        slider_1 = 1'b0;
  logic        slider_2 = 1'b0;
  logic        slider_3 = 1'b0;
  logic        slider_4 = 1'b0;
  logic [13:0] acc;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;
  bit m_ovf  = 1'b0;

  calculator_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .button_clr (button_clr),
    .button_ent (button_ent),
    .slider_1   (slider_1),
    .slider_2   (slider_2),
    .slider_3   (slider_3),
    .slider_4   (slider_4),
    .acc        (acc),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sval_of(input logic [3:0] s);
    return (s[3] ? 1000 : 0) + (s[2] ? 100 : 0) + (s[1] ? 10 : 0) + (s[0] ? 1 : 0);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void model_add(input int sv);
    int s;
    s = m_acc + sv;
    if (s <= MAX) m_acc = s;
    else begin
      m_ovf = 1'b1;
      m_acc = SAT ? MAX : s - (MAX + 1);
    end
  endfunction

  function automatic void set_sliders(input logic [3:0] s);
    {slider_4, slider_3, slider_2, slider_1} = s;
  endfunction

  task automatic do_reset();
    reset = 1'b1; button_clr = 1'b0; button_ent = 1'b0; set_sliders(4'b0000);
    tick(); tick();
    reset = 1'b0;
    m_acc = 0; m_ovf = 1'b0;
  endtask

  // Counts cycles from the event edge until bcd_valid returns (bounded).
  task automatic wait_valid(inout int n);
    while (!bcd_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic do_enter(input logic [3:0] s, output int n);
    set_sliders(s);
    button_ent = 1'b1;
    tick();
    model_add(sval_of(s));
    n = 0;
    wait_valid(n);
    button_ent = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (acc !== 14'd0 || bcd !== 16'h0000 || bcd_valid !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: acc=%0d bcd=%h valid=%b busy=%b ovf=%b, required 0 0000 1 0 0",
               acc, bcd, bcd_valid, busy, overflow);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (acc !== 14'd0 || busy !== 1'b0 || bcd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: acc=%0d busy=%b valid=%b, required 0 0 1", acc, busy, bcd_valid);
    end
  endtask

  task automatic test_basic_add();
    int n;
    do_reset();
    set_sliders(4'b1001);
    button_ent = 1'b1;
    tick();
    model_add(1001);
    checks++;
    if (acc !== 14'd1001 || busy !== 1'b1 || bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_acc: acc=%0d busy=%b valid=%b, required 1001 1 0", acc, busy, bcd_valid);
    end
    n = 0;
    wait_valid(n);
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d, required 15", n);
    end
    checks++;
    if (bcd !== 16'h1001 || bcd_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_bcd: bcd=%h valid=%b busy=%b, required 1001 1 0", bcd, bcd_valid, busy);
    end
    button_ent = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    set_sliders(4'b1111);
    button_ent = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (acc !== 14'd1111 || bcd !== 16'h1111 || bcd_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_single: acc=%0d bcd=%h valid=%b, required 1111 1111 1", acc, bcd, bcd_valid);
    end
    button_ent = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int n;
    int exp_acc;
    do_reset();
    for (int i = 0; i < 9; i++) do_enter(4'b1000, n);
    for (int i = 0; i < 5; i++) do_enter(4'b0100, n);
    checks++;
    if (acc !== 14'd9500 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_setup: acc=%0d ovf=%b, required 9500 0", acc, overflow);
    end
    do_enter(4'b1111, n);
    exp_acc = SAT ? 9999 : 611;
    checks++;
    if (acc !== 14'(exp_acc) || overflow !== 1'b1 || bcd !== to_bcd(exp_acc) || n !== 15) begin
      errors++;
      $display("FAIL ovf_add: acc=%0d ovf=%b bcd=%h cycles=%0d, required %0d 1 %h 15",
               acc, overflow, bcd, n, exp_acc, to_bcd(exp_acc));
    end
    do_enter(4'b0001, n);
    checks++;
    if (overflow !== 1'b1 || acc !== 14'(m_acc)) begin
      errors++;
      $display("FAIL ovf_sticky: acc=%0d ovf=%b, required %0d 1", acc, overflow, m_acc);
    end
    button_clr = 1'b1;
    tick();
    n = 0;
    wait_valid(n);
    checks++;
    if (overflow !== 1'b0 || acc !== 14'd0 || bcd !== 16'h0000 || n !== 15) begin
      errors++;
      $display("FAIL ovf_clear: acc=%0d ovf=%b bcd=%h cycles=%0d, required 0 0 0000 15", acc, overflow, bcd, n);
    end
    button_clr = 1'b0;
    tick();
    m_acc = 0; m_ovf = 1'b0;
  endtask

  task automatic test_drop();
    int n;
    do_reset();
    set_sliders(4'b0110);
    button_ent = 1'b1;
    tick();
    model_add(110);
    button_ent = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(); n++; end
    button_ent = 1'b1;
    tick(); n++;
    checks++;
    if (acc !== 14'd110 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_during: acc=%0d busy=%b, required 110 1", acc, busy);
    end
    wait_valid(n);
    checks++;
    if (acc !== 14'd110 || bcd !== 16'h0110 || n !== 15) begin
      errors++;
      $display("FAIL drop_result: acc=%0d bcd=%h cycles=%0d, required 110 0110 15", acc, bcd, n);
    end
    button_ent = 1'b0;
    tick();
  endtask

  task automatic test_clr_ent();
    int n;
    do_reset();
    for (int i = 0; i < 2; i++) do_enter(4'b0100, n);
    for (int i = 0; i < 5; i++) do_enter(4'b0010, n);
    checks++;
    if (acc !== 14'd250) begin
      errors++;
      $display("FAIL clr_setup: acc=%0d, required 250", acc);
    end
    set_sliders(4'b1111);
    button_clr = 1'b1;
    button_ent = 1'b1;
    tick();
    checks++;
    if (acc !== 14'd0 || overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_priority: acc=%0d ovf=%b busy=%b, required 0 0 1", acc, overflow, busy);
    end
    n = 0;
    wait_valid(n);
    checks++;
    if (acc !== 14'd0 || bcd !== 16'h0000 || n !== 15) begin
      errors++;
      $display("FAIL clr_result: acc=%0d bcd=%h cycles=%0d, required 0 0000 15", acc, bcd, n);
    end
    button_clr = 1'b0;
    button_ent = 1'b0;
    tick();
    m_acc = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    set_sliders(4'b1111);
    button_ent = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    button_ent = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || bcd_valid !== 1'b1 || acc !== 14'd0 || bcd !== 16'h0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b acc=%0d bcd=%h ovf=%b, required 0 1 0 0000 0",
               busy, bcd_valid, acc, bcd, overflow);
    end
    // A button already held when reset releases produces one event.
    button_ent = 1'b1;
    set_sliders(4'b0001);
    tick();
    reset = 1'b0;
    m_acc = 0; m_ovf = 1'b0;
    tick();
    n = 0;
    wait_valid(n);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (acc !== 14'd1 || bcd !== 16'h0001 || n !== 15) begin
      errors++;
      $display("FAIL reset_held: acc=%0d bcd=%h cycles=%0d, required 1 0001 15", acc, bcd, n);
    end
    button_ent = 1'b0;
    tick();
    m_acc = 1;
  endtask

  task automatic test_random();
    int n, k, mode, expn;
    logic [3:0] s;
    for (int op = 0; op < 30; op++) begin
      s = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 3);
      k = $urandom_range(2, 12);
      expn = 15;
      set_sliders(s);
      button_ent = 1'b1;
      tick();
      model_add(sval_of(s));
      button_ent = 1'b0;
      checks++;
      if (acc !== 14'(m_acc) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rand_add op%0d: acc=%0d busy=%b, required %0d 1", op, acc, busy, m_acc);
      end
      n = 0;
      while (n < 60) begin
        if (n + 1 == k && mode == 1) button_ent = 1'b1;
        if (n + 1 == k && mode == 2) button_clr = 1'b1;
        tick();
        n++;
        if (n == k) begin
          button_ent = 1'b0;
          button_clr = 1'b0;
          if (mode == 2) begin
            m_acc = 0; m_ovf = 1'b0; expn = k + 15;
            checks++;
            if (acc !== 14'd0 || overflow !== 1'b0) begin
              errors++;
              $display("FAIL rand_midclr op%0d: acc=%0d ovf=%b, required 0 0", op, acc, overflow);
            end
          end
        end
        if (bcd_valid) break;
      end
      checks++;
      if (n !== expn || acc !== 14'(m_acc) || bcd !== to_bcd(m_acc) || overflow !== m_ovf || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_done op%0d: cycles=%0d acc=%0d bcd=%h ovf=%b busy=%b, required %0d %0d %h %b 0",
                 op, n, acc, bcd, overflow, busy, expn, m_acc, to_bcd(m_acc), m_ovf);
      end
      button_ent = 1'b0;
      button_clr = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_hold();
    test_overflow();
    test_drop();
    test_clr_ent();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
